vectorize: RTL and testbench

- CORDIC vectoring unit: converts a Cartesian I/Q sample to magnitude and phase, i.e. atan2(q, i) plus a gain-scaled |v|.
- Inverse of the rotation CORDIC: its phase output uses the same argument format that the rotator accepts as input.
- Sits in the receive path ahead of carrier/phase tracking.
- Fully pipelined, one sample per cycle, AXI-Stream-style valid/ready with backpressure.

---
 rtl/cordic_pkg.sv | 51 +++++
 rtl/vectorize_stage.sv | 58 +++++
 rtl/vectorize.sv | 159 +++++++++++++++
 tb/tb_vectorize.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default working widths, angle constants, gain and
// the elaboration-time arctangent table generator used by rotator and vectorizer.
package cordic_pkg;

   localparam int unsigned CORDIC_WIDTH = 16;
   localparam int unsigned CORDIC_DEPTH = 16;
   localparam int unsigned CORDIC_ACC_W = CORDIC_WIDTH + 2;
   localparam int unsigned CORDIC_ARG_W = 2 * CORDIC_WIDTH;

   typedef logic signed [CORDIC_ACC_W-1:0] cordic_acc_t;
   typedef logic signed [CORDIC_ARG_W-1:0] cordic_arg_t;

   localparam real CORDIC_PI_REAL = 3.14159265358979323846;

   // Product of sqrt(1 + 2^-2n) for n = 1..16
   localparam real CORDIC_GAIN = 1.1644353;

   localparam cordic_arg_t PI   = 32'h8000_0000;
   localparam cordic_arg_t PI_2 = 32'h4000_0000;

   function automatic logic [63:0] cordic_pi(input int unsigned argbits);
      return 64'(1) << (argbits - 1);
   endfunction

   function automatic logic [63:0] cordic_pi_2(input int unsigned argbits);
      return 64'(1) << (argbits - 2);
   endfunction

   // round(atan(2^-(k+1)) * 2^(argbits-1) / pi), atan by Taylor series (|t| <= 0.5)
   function automatic logic [63:0] cordic_phi(input int unsigned k, input int unsigned argbits);
      real t;
      real t2;
      real term;
      real acc;
      real scale;
      t = 1.0;
      for (int unsigned j = 0; j <= k; j++) t = t / 2.0;
      t2   = t * t;
      term = t;
      acc  = 0.0;
      for (int n = 0; n < 24; n++) begin
         if ((n % 2) == 0) acc = acc + term / real'(2 * n + 1);
         else              acc = acc - term / real'(2 * n + 1);
         term = term * t2;
      end
      scale = 1.0;
      for (int unsigned j = 1; j < argbits; j++) scale = scale * 2.0;
      return 64'(longint'(acc * scale / CORDIC_PI_REAL));
   endfunction

endpackage

// File: rtl/vectorize_stage.sv
// One CORDIC vectoring micro-rotation: drives y toward zero, accumulating the
// applied angle in z. Control bits are reset, datapath is not.
module vectorize_stage #(
   parameter int unsigned ACC_W = 18,
   parameter int unsigned ARG_W = 32,
   parameter int unsigned SHIFT = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic signed [ACC_W-1:0] x_in,
   input  logic signed [ACC_W-1:0] y_in,
   input  logic signed [ARG_W-1:0] z_in,
   input  logic                    zero_in,
   input  logic                    valid_in,
   input  logic                    last_in,
   input  logic signed [ARG_W-1:0] phi,
   output logic signed [ACC_W-1:0] x_out,
   output logic signed [ACC_W-1:0] y_out,
   output logic signed [ARG_W-1:0] z_out,
   output logic                    zero_out,
   output logic                    valid_out,
   output logic                    last_out
);

   logic signed [ACC_W-1:0] x_sh;
   logic signed [ACC_W-1:0] y_sh;

   assign x_sh = x_in >>> SHIFT;
   assign y_sh = y_in >>> SHIFT;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end else if (en) begin
         valid_out <= valid_in;
         last_out  <= last_in;
      end
   end

   // Rotate against the sign of y; z wraps naturally at ARG_W bits
   always_ff @(posedge clk) begin
      if (en) begin
         if (!y_in[ACC_W-1]) begin
            x_out <= x_in + y_sh;
            y_out <= y_in - x_sh;
            z_out <= z_in + phi;
         end else begin
            x_out <= x_in - y_sh;
            y_out <= y_in + x_sh;
            z_out <= z_in - phi;
         end
         zero_out <= zero_in;
      end
   end

endmodule

// File: rtl/vectorize.sv
// CORDIC vectoring unit: {q,i} in, {phase, gain-scaled magnitude} out, fully
// pipelined with valid/ready backpressure stalling the whole pipe at once.
module vectorize
   import cordic_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [2*WIDTH-1:0] s_data,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [3*WIDTH-1:0] m_data,
   output logic               m_last
);

   localparam int unsigned ACC_W = WIDTH + 2;
   localparam int unsigned ARG_W = 2 * WIDTH;

   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [ARG_W-1:0] arg_t;

   localparam arg_t PI_ARG   = ARG_W'(cordic_pi(ARG_W));
   localparam arg_t PI_2_ARG = ARG_W'(cordic_pi_2(ARG_W));

   logic adv;
   acc_t i_ext;
   acc_t q_ext;
   acc_t abs_i;
   acc_t abs_q;
   acc_t x0_c;
   acc_t y0_c;
   arg_t z0_c;
   logic zero0_c;

   acc_t x_s0;
   acc_t y_s0;
   arg_t z_s0;
   logic zero_s0;
   logic valid_s0;
   logic last_s0;

   acc_t x_p     [DEPTH+1];
   acc_t y_p     [DEPTH+1];
   arg_t z_p     [DEPTH+1];
   logic zero_p  [DEPTH+1];
   logic valid_p [DEPTH+1];
   logic last_p  [DEPTH+1];

   arg_t             phase_out;
   logic [WIDTH-1:0] mag_out;
   logic             unused_y;

   assign adv     = !m_valid || m_ready;
   assign s_ready = adv;

   // Pre-rotation into the right half-plane sector |angle| <= pi/4
   always_comb begin
      i_ext   = ACC_W'($signed(s_data[WIDTH-1:0]));
      q_ext   = ACC_W'($signed(s_data[2*WIDTH-1:WIDTH]));
      abs_i   = i_ext[ACC_W-1] ? -i_ext : i_ext;
      abs_q   = q_ext[ACC_W-1] ? -q_ext : q_ext;
      x0_c    = i_ext;
      y0_c    = q_ext;
      z0_c    = '0;
      zero0_c = (i_ext == '0) && (q_ext == '0);
      if (!i_ext[ACC_W-1] && (abs_i >= abs_q)) begin
         x0_c = i_ext;
         y0_c = q_ext;
         z0_c = '0;
      end else if (q_ext > abs_i) begin
         x0_c = q_ext;
         y0_c = -i_ext;
         z0_c = PI_2_ARG;
      end else if (i_ext[ACC_W-1] && (abs_i >= abs_q)) begin
         x0_c = -i_ext;
         y0_c = -q_ext;
         z0_c = PI_ARG;
      end else begin
         x0_c = -q_ext;
         y0_c = i_ext;
         z0_c = -PI_2_ARG;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_s0 <= 1'b0;
         last_s0  <= 1'b0;
      end else if (adv) begin
         valid_s0 <= s_valid;
         last_s0  <= s_last;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         x_s0    <= x0_c;
         y_s0    <= y0_c;
         z_s0    <= z0_c;
         zero_s0 <= zero0_c;
      end
   end

   assign x_p[0]     = x_s0;
   assign y_p[0]     = y_s0;
   assign z_p[0]     = z_s0;
   assign zero_p[0]  = zero_s0;
   assign valid_p[0] = valid_s0;
   assign last_p[0]  = last_s0;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      localparam arg_t PHI = ARG_W'(cordic_phi(k, ARG_W));
      vectorize_stage #(
         .ACC_W (ACC_W),
         .ARG_W (ARG_W),
         .SHIFT (k + 1)
      ) u_stage (
         .clk       (clk),
         .reset_n   (reset_n),
         .en        (adv),
         .x_in      (x_p[k]),
         .y_in      (y_p[k]),
         .z_in      (z_p[k]),
         .zero_in   (zero_p[k]),
         .valid_in  (valid_p[k]),
         .last_in   (last_p[k]),
         .phi       (PHI),
         .x_out     (x_p[k+1]),
         .y_out     (y_p[k+1]),
         .z_out     (z_p[k+1]),
         .zero_out  (zero_p[k+1]),
         .valid_out (valid_p[k+1]),
         .last_out  (last_p[k+1])
      );
   end

   // A zero vector has no defined angle; force a clean 0/0 result
   assign phase_out = zero_p[DEPTH] ? '0 : z_p[DEPTH];
   assign mag_out   = zero_p[DEPTH] ? '0 : x_p[DEPTH][WIDTH-1:0];
   assign unused_y  = ^y_p[DEPTH];

   assign m_valid = valid_p[DEPTH];
   assign m_last  = last_p[DEPTH];
   assign m_data  = {phase_out, mag_out};

`ifndef SYNTHESIS
   a_mag_range : assert property (@(posedge clk) disable iff (!reset_n)
      m_valid |-> (x_p[DEPTH][ACC_W-1:WIDTH] == '0));
   a_hold : assert property (@(posedge clk) disable iff (!reset_n)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));
   a_quiet_in_reset : assert property (@(posedge clk) !reset_n |-> !m_valid);
`endif

endmodule

// File: tb/tb_vectorize.sv
// Scoreboard bench for vectorize: directed I/Q vectors with hand-computed
// magnitude/phase, random backpressure, stall hold and async reset flush.
module tb_vectorize;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned DEPTH  = 16;
   localparam int          NVEC   = 10;
   localparam int          MAG_TOL = DEPTH / 4 + 1;
   localparam int          PH_TOL  = 1 << (2 * WIDTH - DEPTH);

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic               s_valid = 1'b0;
   logic               s_ready;
   logic [2*WIDTH-1:0] s_data = '0;
   logic               s_last = 1'b0;
   logic               m_valid;
   logic               m_ready = 1'b1;
   logic [3*WIDTH-1:0] m_data;
   logic               m_last;

   typedef struct {
      int idx;
      int mag;
      int ph;
      bit last;
      int mtol;
      int ptol;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ready_mode = 0;

   // i, q, round(|v|*G), round(atan2(q,i)*2^31/pi)
   int vi   [NVEC] = '{16384, 0, -16384, 0, -32768, 0, 16384, 32767, 30000, -20000};
   int vq   [NVEC] = '{0, 16384, 0, -16384, -32768, 0, 16384, 0, -20000, 25000};
   int vmag [NVEC] = '{19078, 19078, 19078, 19078, 53961, 0, 26981, 38155, 41984, 37280};
   int vph  [NVEC] = '{0, 1073741824, 32'h8000_0000, -1073741824, -1610612736, 0,
                       536870912, 0, -401938162, 1534971302};

   vectorize #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_last  (s_last),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;

   task automatic check_int(input string name, input longint act, input longint exp, input longint tol);
      longint d;
      checks++;
      d = act - exp;
      if (d < 0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   task automatic check_phase(input string name, input int act, input int exp, input int tol);
      logic signed [31:0] d;
      longint ad;
      checks++;
      d  = 32'(act - exp);
      ad = longint'(d);
      if (ad < 0) ad = -ad;
      if (ad > longint'(tol)) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
      end
   endtask

   // Monitor: owns m_ready, pops the scoreboard on each handshake
   initial begin : monitor
      logic [3*WIDTH-1:0] held;
      logic               held_last;
      bit                 stalled;
      exp_t               e;
      int                 mag;
      int                 ph;
      stalled   = 1'b0;
      held      = '0;
      held_last = 1'b0;
      forever begin
         @(negedge clk);
         case (ready_mode)
            1:       m_ready = ($urandom_range(0, 3) != 0);
            2:       m_ready = 1'b0;
            default: m_ready = 1'b1;
         endcase
         #1;
         if (!reset_n) begin
            stalled = 1'b0;
            continue;
         end
         if (stalled) begin
            checks++;
            if (!m_valid || (m_data !== held) || (m_last !== held_last)) begin
               errors++;
               $display("FAIL hold: valid %0b data %h last %0b, expected valid 1 data %h last %0b",
                        m_valid, m_data, m_last, held, held_last);
            end
         end
         stalled = 1'b0;
         if (m_valid && m_ready) begin
            mag = int'(m_data[WIDTH-1:0]);
            ph  = int'($signed(m_data[3*WIDTH-1:WIDTH]));
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: mag %0d phase %0d, expected no output", mag, ph);
            end else begin
               e = sb.pop_front();
               check_int($sformatf("mag[v%0d]", e.idx), longint'(mag), longint'(e.mag), longint'(e.mtol));
               check_phase($sformatf("phase[v%0d]", e.idx), ph, e.ph, e.ptol);
               check_int($sformatf("last[v%0d]", e.idx), longint'(m_last), longint'(e.last), 0);
            end
         end else if (m_valid) begin
            stalled   = 1'b1;
            held      = m_data;
            held_last = m_last;
         end
      end
   end

   function automatic exp_t make_exp(input int idx, input bit last);
      exp_t e;
      e.idx  = idx;
      e.mag  = vmag[idx];
      e.ph   = vph[idx];
      e.last = last;
      e.mtol = ((vi[idx] == 0) && (vq[idx] == 0)) ? 0 : MAG_TOL;
      e.ptol = ((vi[idx] == 0) && (vq[idx] == 0)) ? 0 : PH_TOL;
      return e;
   endfunction

   task automatic send(input int idx, input bit last, input int gap);
      int wait_cnt;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = {WIDTH'(vq[idx]), WIDTH'(vi[idx])};
      s_last  = last;
      #2;
      wait_cnt = 0;
      while (!s_ready && wait_cnt < 200) begin
         @(negedge clk);
         #2;
         wait_cnt++;
      end
      if (!s_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: s_ready 0 after %0d cycles, expected 1", wait_cnt);
      end else begin
         sb.push_back(make_exp(idx, last));
         @(posedge clk);
      end
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_int("drain_pending", longint'(sb.size()), 0, 0);
      repeat (5) @(negedge clk);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int lat;
      int n;
      repeat (3) @(negedge clk);
      #2;
      check_int("reset_m_valid", longint'(m_valid), 0, 0);
      check_int("reset_m_last", longint'(m_last), 0, 0);
      check_int("reset_s_ready", longint'(s_ready), 1, 0);
      @(posedge clk);
      #3 reset_n = 1'b1;

      // Back-to-back, no backpressure
      for (int v = 0; v < NVEC; v++) send(v, v == NVEC - 1, 0);
      drain();

      // Random backpressure and input gaps, several packets
      ready_mode = 1;
      for (int r = 0; r < 5; r++)
         for (int v = 0; v < NVEC; v++) send(v, v == NVEC - 1, int'($urandom_range(0, 2)));
      drain();

      // Fill with samples while stalled, then reset mid-stream
      ready_mode = 2;
      for (int v = 0; v < NVEC; v++) send(v, 1'b0, 0);
      n = 0;
      while (!m_valid && n < 40) begin
         @(negedge clk);
         #2;
         n++;
      end
      check_int("stalled_output_present", longint'(m_valid), 1, 0);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check_int("async_reset_m_valid", longint'(m_valid), 0, 0);
      check_int("async_reset_s_ready", longint'(s_ready), 1, 0);
      sb.delete();
      ready_mode = 0;
      repeat (2) @(negedge clk);
      #2;
      check_int("in_reset_m_valid", longint'(m_valid), 0, 0);
      @(posedge clk);
      #3 reset_n = 1'b1;

      // First sample after reset: latency and no stale data ahead of it
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = {WIDTH'(vq[4]), WIDTH'(vi[4])};
      s_last  = 1'b1;
      sb.push_back(make_exp(4, 1'b1));
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat = 1;
      while (!m_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_int("post_reset_latency", longint'(lat), longint'(DEPTH + 1), 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
